// File: rtl/rv32i_mc_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared variable-latency memory port.
// Define ILLEGAL_TRAP_EN to trap on unrecognised opcodes; otherwise they retire as a non-counted NOP.
module rv32i_mc_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t     cur, nxt;
    logic [7:0] waitCnt;
    logic       trapReg;
    logic       retire;
    logic       enterTrap;
    logic       timedOut;
    logic       decA, decB;
    logic [1:0] decOp;
    logic       unusedFunc3;

    assign unusedFunc3 = ^func3;
    assign state       = cur;
    assign trap        = trapReg;
    assign timedOut    = !mem_ready && (waitCnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= FETCH;
            waitCnt <= 8'd0;
            trapReg <= 1'b0;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (enterTrap)
                trapReg <= 1'b1;
            if (retire)
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            if (nxt != cur && (nxt == FETCH || nxt == MEM))
                waitCnt <= 8'd0;
            else if ((cur == FETCH || cur == MEM) && !mem_ready)
                waitCnt <= waitCnt + 8'd1;
        end
    end

    // ALU setup is held from EXEC through MEM/WB so the address and writeback result stay valid.
    always_comb begin
        decA  = 1'b0;
        decB  = 1'b0;
        decOp = 2'd0;
        case (opcode)
            OP_R:               decOp = 2'd2;
            OP_I:               begin decB = 1'b1; decOp = 2'd2; end
            OP_LOAD, OP_STORE:  decB = 1'b1;
            OP_BRANCH:          decOp = 2'd1;
            OP_JAL, OP_AUIPC:   begin decA = 1'b1; decB = 1'b1; end
            OP_JALR:            decB = 1'b1;
            OP_LUI:             decOp = 2'd3;
            default:            ;
        endcase
    end

    always_comb begin
        nxt          = cur;
        retire       = 1'b0;
        enterTrap    = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = 2'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        // Outputs are forced low while reset is held so a pending request drops immediately.
        if (!rst) begin
            case (cur)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        nxt   = DECODE;
                    end else if (timedOut) begin
                        nxt       = TRAP;
                        enterTrap = 1'b1;
                    end
                end
                DECODE: nxt = EXEC;
                EXEC: begin
                    alu_src_a = decA;
                    alu_src_b = decB;
                    alu_op    = decOp;
                    case (opcode)
                        OP_R, OP_I, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: nxt = WB;
                        OP_LOAD, OP_STORE: nxt = MEM;
                        OP_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = branch_taken ? 2'd1 : 2'd0;
                            retire = 1'b1;
                            nxt    = FETCH;
                        end
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            nxt       = TRAP;
                            enterTrap = 1'b1;
`else
                            pc_we = 1'b1;
                            nxt   = FETCH;
`endif
                        end
                    endcase
                end
                MEM: begin
                    alu_src_a    = decA;
                    alu_src_b    = decB;
                    alu_op       = decOp;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_STORE);
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            pc_we  = 1'b1;
                            retire = 1'b1;
                            nxt    = FETCH;
                        end else begin
                            nxt = WB;
                        end
                    end else if (timedOut) begin
                        nxt       = TRAP;
                        enterTrap = 1'b1;
                    end
                end
                WB: begin
                    alu_src_a = decA;
                    alu_src_b = decB;
                    alu_op    = decOp;
                    reg_we    = 1'b1;
                    pc_we     = 1'b1;
                    retire    = 1'b1;
                    nxt       = FETCH;
                    case (opcode)
                        OP_LOAD: wb_sel = 2'd1;
                        OP_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
                        OP_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
                        default: ;
                    endcase
                end
                TRAP: nxt = TRAP;
                default: nxt = FETCH;
            endcase
        end
    end

endmodule
